// File: rtl/uart_tx_arbiter.sv
// Three-requester byte arbiter in front of a UART transmitter. Round-robin
// arbitration with message locking, and a timeout that releases an idle lock.
module uart_tx_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_data,
    input  logic [2:0]  req_last,
    output logic [2:0]  req_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [1:0]  grant,
    output logic        lock_timeout
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;
    localparam logic [1:0] NO_OWNER     = 2'd3;
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(LOCK_TIMEOUT);

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  grant_r;
    logic [1:0]  rr_ptr_r;
    logic [15:0] idle_cnt_r;
    logic [7:0]  tx_byte_r;
    logic        tx_start_r;
    logic        lock_timeout_r;

    logic [3:0]  valid4_s;
    logic [3:0]  last4_s;
    logic [1:0]  cand1_s;
    logic [1:0]  cand2_s;
    logic [1:0]  sel_idx_s;
    logic        sel_valid_s;
    logic [7:0]  sel_byte_s;
    logic        accept_s;
    logic        owner_idle_s;

    // Padding to four entries lets the "no owner" code index safely.
    assign valid4_s = {1'b0, req_valid};
    assign last4_s  = {1'b0, req_last};
    assign cand1_s  = next_idx(rr_ptr_r);
    assign cand2_s  = next_idx(cand1_s);

    // Pick the lock owner if one exists, otherwise the first valid requester from rr_ptr.
    always_comb begin
        sel_idx_s   = 2'd0;
        sel_valid_s = 1'b0;
        if (grant_r != NO_OWNER) begin
            sel_idx_s   = grant_r;
            sel_valid_s = valid4_s[grant_r];
        end else if (valid4_s[rr_ptr_r]) begin
            sel_idx_s   = rr_ptr_r;
            sel_valid_s = 1'b1;
        end else if (valid4_s[cand1_s]) begin
            sel_idx_s   = cand1_s;
            sel_valid_s = 1'b1;
        end else if (valid4_s[cand2_s]) begin
            sel_idx_s   = cand2_s;
            sel_valid_s = 1'b1;
        end else begin
            sel_idx_s   = 2'd0;
            sel_valid_s = 1'b0;
        end
    end

    // Byte lane of the selected requester.
    always_comb begin
        sel_byte_s = 8'h00;
        case (sel_idx_s)
            2'd0:    sel_byte_s = req_data[7:0];
            2'd1:    sel_byte_s = req_data[15:8];
            2'd2:    sel_byte_s = req_data[23:16];
            default: sel_byte_s = 8'h00;
        endcase
    end

    // req_ready is the acceptance handshake itself, so it reflects the current cycle.
    assign accept_s     = (state_r == ST_IDLE) && !tx_busy && sel_valid_s && !reset;
    assign owner_idle_s = (state_r == ST_IDLE) && (grant_r != NO_OWNER) && !valid4_s[grant_r];
    assign req_ready    = accept_s ? (3'b001 << sel_idx_s) : 3'b000;

    // Transfer sequencing, lock ownership, round-robin pointer and idle-lock timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            grant_r        <= NO_OWNER;
            rr_ptr_r       <= 2'd0;
            idle_cnt_r     <= 16'd0;
            tx_byte_r      <= 8'h00;
            tx_start_r     <= 1'b0;
            lock_timeout_r <= 1'b0;
        end else begin
            tx_start_r     <= 1'b0;
            lock_timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r    <= ST_START;
                        tx_start_r <= 1'b1;
                        tx_byte_r  <= sel_byte_s;
                        idle_cnt_r <= 16'd0;
                        if (last4_s[sel_idx_s]) begin
                            grant_r  <= NO_OWNER;
                            rr_ptr_r <= next_idx(sel_idx_s);
                        end else begin
                            grant_r <= sel_idx_s;
                        end
                    end else if (grant_r == NO_OWNER) begin
                        idle_cnt_r <= 16'd0;
                    end else if (owner_idle_s) begin
                        // Release happens on the edge where the count would reach the limit.
                        if ((idle_cnt_r + 16'd1) == TIMEOUT_LIMIT) begin
                            grant_r        <= NO_OWNER;
                            rr_ptr_r       <= next_idx(grant_r);
                            idle_cnt_r     <= 16'd0;
                            lock_timeout_r <= 1'b1;
                        end else begin
                            idle_cnt_r <= idle_cnt_r + 16'd1;
                        end
                    end else begin
                        idle_cnt_r <= idle_cnt_r;
                    end
                end
                ST_START: begin
                    state_r <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_r <= ST_WAIT_DONE;
                    end else begin
                        state_r <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_byte      = tx_byte_r;
    assign tx_start     = tx_start_r;
    assign grant        = grant_r;
    assign lock_timeout = lock_timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by random
// traffic, all checked each cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic        tx_busy;
    logic [1:0]  grant;
    logic        lock_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.LOCK_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_byte(tx_byte),
        .tx_start(tx_start), .tx_busy(tx_busy), .grant(grant), .lock_timeout(lock_timeout)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: lock owner (3 = none), round-robin start, idle count, transfer progress.
    int          m_owner = 3;
    int          m_rr = 0;
    int          m_idle = 0;
    logic [7:0]  m_byte = 8'h00;
    bit          m_start_due = 1'b0;
    bit          m_in_flight = 1'b0;
    bit          m_busy_seen = 1'b0;
    bit          m_to = 1'b0;

    int          tx_mode = 0;     // 0: bench drives tx_busy, 1: 10-cycle pulse, 2: random
    int          busy_left = 0;
    logic [2:0]  seen_ready;
    logic        seen_start;
    logic        seen_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int pick();
        if (m_owner != 3) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_rr + k) % 3;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [2:0] v);
        if (v == 3'b001) return 0;
        if (v == 3'b010) return 1;
        if (v == 3'b100) return 2;
        return -1;
    endfunction

    // One clock cycle: settle inputs, compare outputs with the model, advance the model.
    task automatic tick();
        int         p;
        bit         idle;
        logic [2:0] exp_ready;
        if (tx_mode == 1) tx_busy = (busy_left > 0);
        else if (tx_mode == 2) tx_busy = (($urandom % 3) == 0);
        #1;
        idle = !m_start_due && !m_in_flight;
        p = pick();
        exp_ready = (idle && !tx_busy && !reset && p >= 0) ? 3'(1 << p) : 3'b000;
        seen_ready = req_ready;
        seen_start = tx_start;
        seen_busy  = tx_busy;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("tx_start", 32'(tx_start), 32'(m_start_due));
        check("tx_byte", 32'(tx_byte), 32'(m_byte));
        check("grant", 32'(grant), 32'(m_owner));
        check("lock_timeout", 32'(lock_timeout), 32'(m_to));
        if (tx_mode == 1) busy_left = m_start_due ? 10 : ((busy_left > 0) ? busy_left - 1 : 0);
        if (reset) begin
            m_owner = 3; m_rr = 0; m_idle = 0; m_byte = 8'h00;
            m_start_due = 0; m_in_flight = 0; m_busy_seen = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (idle) begin
                if (!tx_busy && p >= 0) begin
                    m_byte = req_data[p*8 +: 8];
                    m_start_due = 1;
                    m_idle = 0;
                    if (req_last[p]) begin m_owner = 3; m_rr = (p + 1) % 3; end
                    else m_owner = p;
                end else if (m_owner == 3) begin
                    m_idle = 0;
                end else if (!req_valid[m_owner]) begin
                    m_idle++;
                    if (m_idle == 4) begin
                        m_rr = (m_owner + 1) % 3; m_owner = 3; m_idle = 0; m_to = 1;
                    end
                end
            end else if (m_start_due) begin
                m_start_due = 0; m_in_flight = 1; m_busy_seen = 0;
            end else if (!m_busy_seen) begin
                if (tx_busy) m_busy_seen = 1;
            end else if (!tx_busy) begin
                m_in_flight = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        busy_left = 0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int busy_acc;
        int order[4];
        int rr_exp[4];
        int lock_exp[4];
        logic [7:0] s1[3];
        int k1;
        bit got_to;
        logic [1:0] grant_at_to;
        int next_served;
        int accepts;
        int starts;

        reset = 1'b1; req_valid = 3'b000; req_data = 24'h000000; req_last = 3'b000; tx_busy = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        reset = 1'b0;

        // Single byte: accept at T, tx_start with the byte at T+1, no lock left behind.
        req_valid = 3'b001; req_data = 24'h000041; req_last = 3'b001; tx_busy = 1'b0;
        tick();
        check("single_ready", 32'(seen_ready), 32'h1);
        req_valid = 3'b000;
        check("single_start", 32'(tx_start), 32'h1);
        check("single_byte", 32'(tx_byte), 32'h41);
        check("single_grant", 32'(grant), 32'h3);
        tick();

        // Round robin under a 10-cycle busy pulse per byte.
        reset_dut();
        tx_mode = 1;
        req_valid = 3'b111; req_last = 3'b111; req_data = 24'($urandom);
        rr_exp = '{0, 1, 2, 0};
        order = '{-1, -1, -1, -1};
        n = 0; busy_acc = 0;
        for (int c = 0; c < 80 && n < 4; c++) begin
            tick();
            if (seen_ready != 3'b000) begin
                order[n] = onehot_idx(seen_ready);
                n++;
                if (seen_busy) busy_acc++;
            end
        end
        check("rr_count", 32'(n), 32'd4);
        for (int k = 0; k < 4; k++) check("rr_order", 32'(order[k]), 32'(rr_exp[k]));
        check("rr_busy_ready", 32'(busy_acc), 32'd0);

        // Lock: requester 1 sends a three-byte message while 0 and 2 wait.
        reset_dut();
        s1 = '{8'h48, 8'h49, 8'h0A};
        lock_exp = '{1, 1, 1, 2};
        order = '{-1, -1, -1, -1};
        k1 = 0; n = 0;
        req_valid = 3'b010; req_data = {8'hC2, s1[0], 8'hC0}; req_last = 3'b101;
        for (int c = 0; c < 100 && n < 4; c++) begin
            tick();
            if (seen_ready != 3'b000) begin
                order[n] = onehot_idx(seen_ready);
                n++;
                if (seen_ready == 3'b010) begin
                    k1++;
                    req_valid = 3'b111;
                    if (k1 < 3) begin
                        req_data[15:8] = s1[k1];
                        req_last[1] = (k1 == 2);
                    end else begin
                        req_valid[1] = 1'b0;
                    end
                end
            end
        end
        for (int k = 0; k < 4; k++) check("lock_order", 32'(order[k]), 32'(lock_exp[k]));

        // Timeout: owner 0 goes quiet, lock released, requester 1 next.
        reset_dut();
        req_valid = 3'b001; req_data = 24'h000055; req_last = 3'b000;
        got_to = 1'b0; grant_at_to = 2'd0; next_served = -1;
        for (int c = 0; c < 60 && next_served < 0; c++) begin
            tick();
            if (seen_ready == 3'b001 && !got_to) begin
                req_valid = 3'b010; req_last = 3'b010;
            end else if (got_to && seen_ready != 3'b000) begin
                next_served = onehot_idx(seen_ready);
            end
            if (!got_to && lock_timeout) begin
                got_to = 1'b1;
                grant_at_to = grant;
            end
        end
        check("to_pulse", 32'(got_to), 32'h1);
        check("to_grant", 32'(grant_at_to), 32'h3);
        check("to_next", 32'(next_served), 32'd1);
        tx_mode = 0;

        // Stuck busy: only one acceptance and one tx_start.
        reset_dut();
        tx_busy = 1'b0;
        req_valid = 3'b001; req_last = 3'b001; req_data = 24'hABCDEF;
        accepts = 0; starts = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            req_valid = 3'b111;
            if (seen_ready != 3'b000) accepts++;
            if (seen_start) starts++;
        end
        check("stuck_accepts", 32'(accepts), 32'd1);
        check("stuck_starts", 32'(starts), 32'd1);

        // Reset mid-transfer in WAIT_DONE with grant=2.
        reset_dut();
        req_valid = 3'b100; req_last = 3'b000; req_data = 24'h770000; tx_busy = 1'b0;
        tick();
        req_valid = 3'b000;
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        check("mid_grant", 32'(grant), 32'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_grant", 32'(grant), 32'h3);
        check("mid_rst_byte", 32'(tx_byte), 32'h0);
        req_valid = 3'b111; req_last = 3'b111; tx_busy = 1'b0;
        tick();
        check("mid_rst_winner", 32'(seen_ready), 32'h1);

        // Random traffic with occasional resets.
        tx_mode = 2;
        for (int c = 0; c < 800; c++) begin
            req_valid = 3'($urandom);
            req_last  = 3'($urandom);
            req_data  = 24'($urandom);
            reset     = (($urandom % 150) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
